// File: rtl/uart_ext.sv
// uart_ext: parametrised full-duplex UART with runtime baud divisor, configurable
// frame format, per-byte error flags and valid/ready handshakes on both sides.
// Optional feature macro: UART_RX_FIFO_EN selects a 2**FIFO_AW-entry RX FIFO;
// without it the RX side has a single holding register.
module uart_ext #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned FIFO_AW   = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [15:0]          baud_div,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd_out,
    input  logic                 rxd_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun
);

    localparam logic [3:0] LastData  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop  = 4'(STOP_BITS - 1);
    localparam bit         HasParity = (PARITY != 0);
    localparam int unsigned EntryW   = DATA_BITS + 2;

    // ---------------------------------------------------------------- tick generator
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] reload;
    logic        tick;

    assign tick = (tick_cnt_q == 16'd0);

    // Free-running down-counter; a new divisor is picked up only at reload.
    always_comb begin
        reload     = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
        tick_cnt_d = tick ? reload : tick_cnt_q - 16'd1;
    end

    // Tick counter register.
    always_ff @(posedge clk_in) begin
        if (rst_in) tick_cnt_q <= 16'd0;
        else        tick_cnt_q <= tick_cnt_d;
    end

    // ---------------------------------------------------------------- transmitter
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

    tx_state_e              tx_state_q, tx_state_d;
    logic [3:0]             tx_phase_q, tx_phase_d;
    logic [3:0]             tx_cnt_q, tx_cnt_d;
    logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic                   tx_par_q, tx_par_d;
    logic                   txd_q, txd_d;

    // TX next state; the line is updated on ticks so each bit spans exactly 16 ticks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_phase_d = tx_phase_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_valid) begin
                    tx_sh_d    = tx_data;
                    tx_par_d   = (PARITY == 1) ? ~(^tx_data) : ^tx_data;
                    tx_phase_d = 4'd0;
                    tx_cnt_d   = 4'd0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tick) begin
                    txd_d      = 1'b0;
                    tx_phase_d = tx_phase_q + 4'd1;
                    if (tx_phase_q == 4'd15) tx_state_d = TxData;
                end
            end
            TxData: begin
                if (tick) begin
                    txd_d      = tx_sh_q[0];
                    tx_phase_d = tx_phase_q + 4'd1;
                    if (tx_phase_q == 4'd15) begin
                        tx_sh_d = tx_sh_q >> 1;
                        if (tx_cnt_q == LastData) begin
                            tx_cnt_d   = 4'd0;
                            tx_state_d = HasParity ? TxParity : TxStop;
                        end else begin
                            tx_cnt_d = tx_cnt_q + 4'd1;
                        end
                    end
                end
            end
            TxParity: begin
                if (tick) begin
                    txd_d      = tx_par_q;
                    tx_phase_d = tx_phase_q + 4'd1;
                    if (tx_phase_q == 4'd15) tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (tick) begin
                    txd_d      = 1'b1;
                    tx_phase_d = tx_phase_q + 4'd1;
                    if (tx_phase_q == 4'd15) begin
                        if (tx_cnt_q == LastStop) tx_state_d = TxIdle;
                        else                      tx_cnt_d   = tx_cnt_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // TX state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_state_q <= TxIdle;
            tx_phase_q <= 4'd0;
            tx_cnt_q   <= 4'd0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_phase_q <= tx_phase_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    assign tx_ready = (tx_state_q == TxIdle);
    assign txd_out  = txd_q;

    // ---------------------------------------------------------------- receiver
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop, RxBreak} rx_state_e;

    logic [1:0]             sync_q;
    logic                   rxd_s;
    rx_state_e              rx_state_q, rx_state_d;
    logic [3:0]             rx_phase_q, rx_phase_d;
    logic [3:0]             rx_cnt_q, rx_cnt_d;
    logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   mid;
    logic                   push, push_fe;
    logic [EntryW-1:0]      push_entry;

    assign rxd_s = sync_q[1];
    assign mid   = tick && (rx_phase_q == 4'd7);

    // Two-flop synchroniser, idle-high after reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rxd_in};
    end

    // RX next state; samples at phase 7, so start-bit alignment carries through the frame.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_phase_d = rx_phase_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sh_d    = rx_sh_q;
        rx_perr_d  = rx_perr_q;
        push       = 1'b0;
        push_fe    = 1'b0;
        if (tick) rx_phase_d = rx_phase_q + 4'd1;
        unique case (rx_state_q)
            RxIdle: begin
                rx_phase_d = 4'd0;
                if (!rxd_s) begin
                    rx_perr_d  = 1'b0;
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (mid) begin
                    rx_cnt_d   = 4'd0;
                    rx_state_d = rxd_s ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (mid) begin
                    rx_sh_d = {rxd_s, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_cnt_q == LastData) begin
                        rx_cnt_d   = 4'd0;
                        rx_state_d = HasParity ? RxParity : RxStop;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 4'd1;
                    end
                end
            end
            RxParity: begin
                if (mid) begin
                    rx_perr_d  = (PARITY == 1) ? ~(^{rx_sh_q, rxd_s}) : ^{rx_sh_q, rxd_s};
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (mid) begin
                    push       = 1'b1;
                    push_fe    = ~rxd_s;
                    rx_state_d = rxd_s ? RxIdle : RxBreak;
                end
            end
            RxBreak: begin
                // Hold off after a framing error until the line is released.
                if (rxd_s) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX state registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_state_q <= RxIdle;
            rx_phase_q <= 4'd0;
            rx_cnt_q   <= 4'd0;
            rx_sh_q    <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_phase_q <= rx_phase_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    assign push_entry = {rx_sh_q, push_fe, rx_perr_q};

    // ---------------------------------------------------------------- RX storage
    logic [EntryW-1:0] out_entry;
    logic              pop, wr_en;
    logic              ovr_q, ovr_d;

`ifdef UART_RX_FIFO_EN
    localparam int unsigned Depth = 2 ** FIFO_AW;

    logic [EntryW-1:0] mem_q [Depth];
    logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              empty, full;

    // Pointer bookkeeping; a pop in the same cycle frees room for a push into a full FIFO.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        pop       = ~empty & rx_ready;
        wr_en     = push & (~full | pop);
        ovr_d     = push & ~wr_en;
        wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        out_entry = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_entry;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_valid = ~empty;
`else
    logic [EntryW-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;

    // Single holding register; same-cycle pop makes room for the incoming byte.
    always_comb begin
        pop          = hold_valid_q & rx_ready;
        wr_en        = push & (~hold_valid_q | pop);
        ovr_d        = push & ~wr_en;
        hold_d       = wr_en ? push_entry : hold_q;
        hold_valid_d = wr_en | (hold_valid_q & ~pop);
        out_entry    = hold_q;
    end

    // Holding register state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ovr_q        <= ovr_d;
        end
    end

    assign rx_valid = hold_valid_q;
`endif

    assign rx_data       = out_entry[EntryW-1:2];
    assign rx_frame_err  = out_entry[1];
    assign rx_parity_err = out_entry[0];
    assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_ext.sv
// Scoreboard bench for uart_ext: an even-parity instance and an odd-parity instance,
// each with a loopback/injection mux on its RxD line and its own checking monitor.
`timescale 1ns/1ps
module tb_uart_ext;

`ifdef UART_RX_FIFO_EN
    localparam int Depth = 4;
`else
    localparam int Depth = 1;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_e = 16'd4, baud_o = 16'd4;
    logic [7:0]  tx_data_e = 8'h00, tx_data_o = 8'h00;
    logic        tx_valid_e = 1'b0, tx_valid_o = 1'b0;
    logic        tx_ready_e, tx_ready_o, txd_e, txd_o;
    logic        drv_e = 1'b1, drv_o = 1'b1, loop_e = 1'b1, loop_o = 1'b0;
    logic        rxd_e, rxd_o;
    logic [7:0]  rx_data_e, rx_data_o;
    logic        fe_e, fe_o, pe_e, pe_o, rxv_e, rxv_o, ovr_e, ovr_o;
    logic        rxr_e = 1'b1, rxr_o = 1'b1;

    assign rxd_e = loop_e ? txd_e : drv_e;
    assign rxd_o = loop_o ? txd_o : drv_o;

    exp_t q_e[$], q_o[$];
    exp_t ex_e, ex_o;
    int   n_vec = 0, n_err = 0;
    int   rx_cnt_e = 0, rx_cnt_o = 0, ovr_cnt_e = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_ext #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(2)) u_even (
        .clk_in(clk), .rst_in(rst), .baud_div(baud_e),
        .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e), .txd_out(txd_e),
        .rxd_in(rxd_e), .rx_data(rx_data_e), .rx_frame_err(fe_e), .rx_parity_err(pe_e),
        .rx_valid(rxv_e), .rx_ready(rxr_e), .rx_overrun(ovr_e)
    );

    uart_ext #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(2)) u_odd (
        .clk_in(clk), .rst_in(rst), .baud_div(baud_o),
        .tx_data(tx_data_o), .tx_valid(tx_valid_o), .tx_ready(tx_ready_o), .txd_out(txd_o),
        .rxd_in(rxd_o), .rx_data(rx_data_o), .rx_frame_err(fe_o), .rx_parity_err(pe_o),
        .rx_valid(rxv_o), .rx_ready(rxr_o), .rx_overrun(ovr_o)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Monitor for the even instance: pops the scoreboard on every accepted byte.
    always @(negedge clk) begin
        if (!rst && rxv_e && rxr_e) begin
            rx_cnt_e++;
            if (q_e.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_even_unexpected: got data=%h fe=%b pe=%b, required no byte",
                         rx_data_e, fe_e, pe_e);
            end else begin
                ex_e = q_e.pop_front();
                chk("rx_even_byte{d,fe,pe}", 32'({rx_data_e, fe_e, pe_e}), 32'(ex_e));
            end
        end
        if (!rst && ovr_e) ovr_cnt_e++;
    end

    // Monitor for the odd instance; it must never overrun.
    always @(negedge clk) begin
        if (!rst && rxv_o && rxr_o) begin
            rx_cnt_o++;
            if (q_o.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_odd_unexpected: got data=%h fe=%b pe=%b, required no byte",
                         rx_data_o, fe_o, pe_o);
            end else begin
                ex_o = q_o.pop_front();
                chk("rx_odd_byte{d,fe,pe}", 32'({rx_data_o, fe_o, pe_o}), 32'(ex_o));
            end
        end
        if (!rst && ovr_o) chk("rx_odd_overrun", 32'(ovr_o), 32'd0);
    end

    // Advance to 1 time unit after the n-th next rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit which, input logic [7:0] b);
        int k = 0;
        while (!(which ? tx_ready_o : tx_ready_e) && k < 3000) begin
            wait_cyc(1);
            k++;
        end
        chk(which ? "tx_odd_ready_wait" : "tx_even_ready_wait",
            32'(which ? tx_ready_o : tx_ready_e), 32'd1);
        if (which) begin tx_data_o = b; tx_valid_o = 1'b1; end
        else       begin tx_data_e = b; tx_valid_e = 1'b1; end
        wait_cyc(1);
        tx_valid_o = 1'b0;
        tx_valid_e = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q_e.size() != 0 || q_o.size() != 0) && k < budget) begin
            wait_cyc(1);
            k++;
        end
        chk("scoreboard_drained", 32'(q_e.size() + q_o.size()), 32'd0);
    endtask

    // Drives n bits LSB first at 64 clk/bit (baud_div 4); leaves the last bit on the line.
    task automatic drive_frame(input bit which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which) drv_o = bits[i];
            else       drv_e = bits[i];
            wait_cyc(64);
        end
    endtask

    task automatic wait_fall_e(output int t);
        int k = 0;
        while (txd_e && k < 200) begin
            wait_cyc(1);
            k++;
        end
        chk("txd_even_start_edge", 32'(txd_e), 32'd0);
        t = cyc;
    endtask

    initial begin
        int t0, t1, c0, o0;
        logic [15:0] fr;

        // Reset values
        wait_cyc(3);
        chk("rst_txd_out", 32'(txd_e), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready_e), 32'd1);
        chk("rst_rx_valid", 32'(rxv_e), 32'd0);
        chk("rst_rx_data", 32'(rx_data_e), 32'd0);
        chk("rst_rx_frame_err", 32'(fe_e), 32'd0);
        chk("rst_rx_parity_err", 32'(pe_e), 32'd0);
        chk("rst_rx_overrun", 32'(ovr_e), 32'd0);
        rst = 1'b0;
        wait_cyc(2);

        // Loopback 0xA5 then 0x3C back to back (even parity, 64 clk per bit)
        q_e.push_back({8'hA5, 1'b0, 1'b0});
        q_e.push_back({8'h3C, 1'b0, 1'b0});
        tx_data_e  = 8'hA5;
        tx_valid_e = 1'b1;
        wait_cyc(1);
        chk("tx_ready_low_after_handshake", 32'(tx_ready_e), 32'd0);
        tx_data_e = 8'h3C;
        wait_fall_e(t0);
        wait_cyc(96);
        chk("txd_a5_bit0", 32'(txd_e), 32'd1);
        wait_cyc(512);
        chk("txd_a5_parity", 32'(txd_e), 32'd0);
        wait_cyc(64);
        chk("txd_a5_stop", 32'(txd_e), 32'd1);
        c0 = 0;
        while (!tx_ready_e && c0 < 200) begin wait_cyc(1); c0++; end
        c0 = 0;
        while (tx_ready_e && c0 < 200) begin wait_cyc(1); c0++; end
        tx_valid_e = 1'b0;
        wait_fall_e(t1);
        chk("tx_frame_period_clk", 32'(t1 - t0), 32'd704);
        drain(3000);

        // Odd parity: injected 0x3C with parity forced 0, then loopback, then baud_div 0
        fr = 16'({1'b1, 1'b0, 8'h3C, 1'b0});
        q_o.push_back({8'h3C, 1'b0, 1'b1});
        drive_frame(1'b1, fr, 11);
        drv_o = 1'b1;
        drain(2000);
        loop_o = 1'b1;
        q_o.push_back({8'h3C, 1'b0, 1'b0});
        send(1'b1, 8'h3C);
        drain(3000);
        baud_o = 16'd0;
        q_o.push_back({8'h96, 1'b0, 1'b0});
        send(1'b1, 8'h96);
        drain(1500);

        // Framing error with line held low for 3 bit times: exactly one byte
        loop_e = 1'b0;
        c0 = rx_cnt_e;
        q_e.push_back({8'h55, 1'b1, 1'b0});
        fr = 16'({1'b0, 1'b0, 8'h55, 1'b0});
        drive_frame(1'b0, fr, 11);
        wait_cyc(3 * 64);
        drv_e = 1'b1;
        wait_cyc(12 * 64);
        chk("break_byte_count", 32'(rx_cnt_e - c0), 32'd1);
        drain(10);

        // 3-tick low glitch on an idle line: no byte
        c0 = rx_cnt_e;
        drv_e = 1'b0;
        wait_cyc(12);
        drv_e = 1'b1;
        wait_cyc(12 * 64);
        chk("glitch_byte_count", 32'(rx_cnt_e - c0), 32'd0);

        // Overrun: Depth bytes fill the store, the next one is dropped
        loop_e = 1'b1;
        rxr_e  = 1'b0;
        o0     = ovr_cnt_e;
        for (int i = 1; i <= Depth; i++) begin
            q_e.push_back({8'(i), 1'b0, 1'b0});
            send(1'b0, 8'(i));
        end
        c0 = 0;
        while (!tx_ready_e && c0 < 1000) begin wait_cyc(1); c0++; end
        wait_cyc(64);
        chk("overrun_before_last", 32'(ovr_cnt_e - o0), 32'd0);
        chk("rx_valid_while_held", 32'(rxv_e), 32'd1);
        send(1'b0, 8'(Depth + 1));
        c0 = 0;
        while (!tx_ready_e && c0 < 1000) begin wait_cyc(1); c0++; end
        wait_cyc(64);
        chk("overrun_on_last", 32'(ovr_cnt_e - o0), 32'd1);
        rxr_e = 1'b1;
        drain(50);
        wait_cyc(2);
        chk("rx_valid_after_reads", 32'(rxv_e), 32'd0);

        // Reset during TX data bit 3 of 0xF0, then a clean 0x81
        send(1'b0, 8'hF0);
        wait_fall_e(t0);
        wait_cyc(4 * 64 + 32);
        chk("txd_f0_bit3", 32'(txd_e), 32'd0);
        rst = 1'b1;
        wait_cyc(1);
        chk("midframe_rst_txd", 32'(txd_e), 32'd1);
        chk("midframe_rst_tx_ready", 32'(tx_ready_e), 32'd1);
        rst = 1'b0;
        wait_cyc(2);
        q_e.push_back({8'h81, 1'b0, 1'b0});
        send(1'b0, 8'h81);
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
